ex_stage: RTL and testbench

Execute stage of the riscy RV32I core, sitting between the ID/EX and EX/MEM boundaries. It decodes instruction fields into the 4-bit ALU control code and selects the operands. It drives the core's integer ALU (a, b, ALUControl in; result, zero out), resolves branches and jumps, and registers the outcome into a valid/ready EX/MEM output register. It is the producer and consumer of the ALU's operand and control interface.

---
 rtl/ex_stage_pkg.sv | 70 +++++++
 rtl/ex_stage_alu.sv | 38 +++
 rtl/ex_stage_alu_op_decode.sv | 67 ++++++
 rtl/ex_stage.sv | 161 ++++++++++++++++
 tb/tb_ex_stage.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_stage_pkg.sv
// Shared ISA constants for the riscy RV32I execute stage: datapath width,
// ALU control codes, opcodes and the decoded-instruction record.
package ex_stage_pkg;

   localparam int ISA_XLEN   = 32;
   localparam int INSN_BYTES = 4;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
   } alu_ctrl_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_SLTU    = 3'b011;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SR      = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef struct packed {
      alu_ctrl_e alu_ctrl;
      logic      a_sel_pc;
      logic      b_sel_imm;
      logic      is_branch;
      logic      is_jal;
      logic      is_jalr;
      logic      is_load;
      logic      is_store;
      logic      writes_rd;
      logic      illegal;
   } dec_t;

   // alt selects SUB for 000 and SRA for 101; callers decide when it applies.
   function automatic alu_ctrl_e funct_to_alu(input logic [2:0] f3, input logic alt);
      alu_ctrl_e c;
      c = ALU_ADD;
      case (f3)
         F3_ADD_SUB: c = alt ? ALU_SUB : ALU_ADD;
         F3_SLL:     c = ALU_SLL;
         F3_SLT:     c = ALU_SLT;
         F3_SLTU:    c = ALU_SLTU;
         F3_XOR:     c = ALU_XOR;
         F3_SR:      c = alt ? ALU_SRA : ALU_SRL;
         F3_OR:      c = ALU_OR;
         F3_AND:     c = ALU_AND;
         default:    c = ALU_ADD;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// Integer ALU of the riscy core: a, b and ALU control in; result and zero out.
module ex_stage_alu
   import ex_stage_pkg::*;
#(
   parameter int XLEN = ISA_XLEN
) (
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  alu_ctrl_e       alu_control,
   output logic [XLEN-1:0] result,
   output logic            zero
);

   localparam int SHW = $clog2(XLEN);

   logic [SHW-1:0] shamt;

   always_comb begin
      shamt  = b[SHW-1:0];
      result = '0;
      case (alu_control)
         ALU_ADD:    result = a + b;
         ALU_SUB:    result = a - b;
         ALU_SLL:    result = a << shamt;
         ALU_SLT:    result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_SLTU:   result = {{(XLEN-1){1'b0}}, (a < b)};
         ALU_XOR:    result = a ^ b;
         ALU_SRL:    result = a >> shamt;
         ALU_SRA:    result = $signed(a) >>> shamt;
         ALU_OR:     result = a | b;
         ALU_AND:    result = a & b;
         ALU_PASS_B: result = b;
         default:    result = '0;
      endcase
      zero = (result == '0);
   end

endmodule

// File: rtl/ex_stage_alu_op_decode.sv
// Combinational decode of opcode/funct3/funct7b5 into ALU control, operand
// selects, instruction class flags and the illegal-encoding flag.
module ex_stage_alu_op_decode
   import ex_stage_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   output dec_t       dec
);

   always_comb begin
      dec          = '0;
      dec.alu_ctrl = ALU_ADD;
      case (opcode)
         OPC_OP: begin
            dec.alu_ctrl  = funct_to_alu(funct3, funct7b5);
            dec.writes_rd = 1'b1;
            dec.illegal   = funct7b5 && (funct3 != F3_ADD_SUB) && (funct3 != F3_SR);
         end
         OPC_OP_IMM: begin
            // funct7b5 is part of the immediate except for the shift-right pair
            dec.alu_ctrl  = funct_to_alu(funct3, funct7b5 && (funct3 == F3_SR));
            dec.b_sel_imm = 1'b1;
            dec.writes_rd = 1'b1;
         end
         OPC_LUI: begin
            dec.alu_ctrl  = ALU_PASS_B;
            dec.b_sel_imm = 1'b1;
            dec.writes_rd = 1'b1;
         end
         OPC_AUIPC: begin
            dec.a_sel_pc  = 1'b1;
            dec.b_sel_imm = 1'b1;
            dec.writes_rd = 1'b1;
         end
         OPC_LOAD: begin
            dec.b_sel_imm = 1'b1;
            dec.is_load   = 1'b1;
            dec.writes_rd = 1'b1;
         end
         OPC_STORE: begin
            dec.b_sel_imm = 1'b1;
            dec.is_store  = 1'b1;
         end
         OPC_BRANCH: begin
            dec.is_branch = 1'b1;
            case (funct3)
               F3_BEQ, F3_BNE:   dec.alu_ctrl = ALU_SUB;
               F3_BLT, F3_BGE:   dec.alu_ctrl = ALU_SLT;
               F3_BLTU, F3_BGEU: dec.alu_ctrl = ALU_SLTU;
               default:          dec.illegal  = 1'b1;
            endcase
         end
         OPC_JAL: begin
            dec.is_jal    = 1'b1;
            dec.writes_rd = 1'b1;
         end
         OPC_JALR: begin
            dec.is_jalr   = 1'b1;
            dec.writes_rd = 1'b1;
         end
         default: dec.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand select, ALU, branch/jump resolution and the
// valid/ready EX/MEM output register with a one-cycle redirect pulse.
module ex_stage
   import ex_stage_pkg::*;
#(
   parameter int XLEN = ISA_XLEN
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            id_valid,
   output logic            id_ready,
   input  logic [XLEN-1:0] id_pc,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic [XLEN-1:0] id_imm,
   input  logic [6:0]      id_opcode,
   input  logic [2:0]      id_funct3,
   input  logic            id_funct7b5,
   input  logic [4:0]      id_rd,
   input  logic            flush,
   output logic            mem_valid,
   input  logic            mem_ready,
   output logic [XLEN-1:0] mem_result,
   output logic [XLEN-1:0] mem_store_data,
   output logic [4:0]      mem_rd,
   output logic [2:0]      mem_funct3,
   output logic            mem_wb_en,
   output logic            mem_is_load,
   output logic            mem_is_store,
   output logic            mem_illegal,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc
);

   // Handshake: an instruction transfers on any edge where valid && ready are both
   // high; the producer holds its payload stable while valid && !ready.

   dec_t            dec;
   logic [XLEN-1:0] alu_a, alu_b, alu_result;
   logic            alu_zero;
   logic [XLEN-1:0] pc_plus4, pc_target, jalr_sum, target;
   logic            br_cond, taken, load;

   logic            mem_valid_q, mem_valid_d, redirect_valid_q, redirect_valid_d;
   logic [XLEN-1:0] mem_result_q, mem_result_d, mem_store_data_q, mem_store_data_d;
   logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
   logic [4:0]      mem_rd_q, mem_rd_d;
   logic [2:0]      mem_funct3_q, mem_funct3_d;
   logic            mem_wb_en_q, mem_wb_en_d, mem_is_load_q, mem_is_load_d;
   logic            mem_is_store_q, mem_is_store_d, mem_illegal_q, mem_illegal_d;

   ex_stage_alu_op_decode u_dec (
      .opcode   (id_opcode),
      .funct3   (id_funct3),
      .funct7b5 (id_funct7b5),
      .dec      (dec)
   );

   ex_stage_alu #(.XLEN(XLEN)) u_alu (
      .a           (alu_a),
      .b           (alu_b),
      .alu_control (dec.alu_ctrl),
      .result      (alu_result),
      .zero        (alu_zero)
   );

   always_comb begin
      alu_a     = dec.a_sel_pc ? id_pc : id_rs1_data;
      alu_b     = dec.b_sel_imm ? id_imm : id_rs2_data;
      pc_plus4  = id_pc + XLEN'(INSN_BYTES);
      pc_target = id_pc + id_imm;
      jalr_sum  = id_rs1_data + id_imm;
      target    = dec.is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : pc_target;

      br_cond = 1'b0;
      case (id_funct3)
         F3_BEQ:          br_cond = alu_zero;
         F3_BNE:          br_cond = !alu_zero;
         F3_BLT, F3_BLTU: br_cond = alu_result[0];
         F3_BGE, F3_BGEU: br_cond = !alu_result[0];
         default:         br_cond = 1'b0;
      endcase
      taken = !dec.illegal && (dec.is_jal || dec.is_jalr || (dec.is_branch && br_cond));
   end

   // During the redirect pulse the offered instruction is wrong-path: take it and drop it.
   assign id_ready = redirect_valid_q || !mem_valid_q || mem_ready;
   assign load     = id_valid && id_ready && !flush && !redirect_valid_q;

   always_comb begin
      mem_valid_d      = mem_valid_q && !mem_ready;
      redirect_valid_d = 1'b0;
      redirect_pc_d    = redirect_pc_q;
      mem_result_d     = mem_result_q;
      mem_store_data_d = mem_store_data_q;
      mem_rd_d         = mem_rd_q;
      mem_funct3_d     = mem_funct3_q;
      mem_wb_en_d      = mem_wb_en_q;
      mem_is_load_d    = mem_is_load_q;
      mem_is_store_d   = mem_is_store_q;
      mem_illegal_d    = mem_illegal_q;
      if (load) begin
         mem_valid_d      = 1'b1;
         redirect_valid_d = taken;
         if (taken) redirect_pc_d = target;
         mem_result_d     = (dec.is_jal || dec.is_jalr) ? pc_plus4 : alu_result;
         mem_store_data_d = id_rs2_data;
         mem_rd_d         = id_rd;
         mem_funct3_d     = id_funct3;
         mem_wb_en_d      = dec.writes_rd && !dec.illegal && (id_rd != '0);
         mem_is_load_d    = dec.is_load && !dec.illegal;
         mem_is_store_d   = dec.is_store && !dec.illegal;
         mem_illegal_d    = dec.illegal;
      end
      if (flush) begin
         mem_valid_d      = 1'b0;
         redirect_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_valid_q      <= 1'b0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         mem_result_q     <= '0;
         mem_store_data_q <= '0;
         mem_rd_q         <= '0;
         mem_funct3_q     <= '0;
         mem_wb_en_q      <= 1'b0;
         mem_is_load_q    <= 1'b0;
         mem_is_store_q   <= 1'b0;
         mem_illegal_q    <= 1'b0;
      end else begin
         mem_valid_q      <= mem_valid_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
         mem_result_q     <= mem_result_d;
         mem_store_data_q <= mem_store_data_d;
         mem_rd_q         <= mem_rd_d;
         mem_funct3_q     <= mem_funct3_d;
         mem_wb_en_q      <= mem_wb_en_d;
         mem_is_load_q    <= mem_is_load_d;
         mem_is_store_q   <= mem_is_store_d;
         mem_illegal_q    <= mem_illegal_d;
      end
   end

   assign mem_valid      = mem_valid_q;
   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;
   assign mem_result     = mem_result_q;
   assign mem_store_data = mem_store_data_q;
   assign mem_rd         = mem_rd_q;
   assign mem_funct3     = mem_funct3_q;
   assign mem_wb_en      = mem_wb_en_q;
   assign mem_is_load    = mem_is_load_q;
   assign mem_is_store   = mem_is_store_q;
   assign mem_illegal    = mem_illegal_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios plus randomized traffic
// against an instruction-level reference model and expected-result queue.
module tb_ex_stage;

   localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011, LUI = 7'b0110111,
                          AUIPC = 7'b0010111, LD = 7'b0000011, ST = 7'b0100011,
                          BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111,
                          BAD = 7'b0001111;

   typedef struct packed {
      logic [31:0] result;
      logic [31:0] store_data;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic        wb, ld, st, ill, taken, res_known;
      logic [31:0] target;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n, id_valid, id_ready, id_funct7b5, flush, mem_ready;
   logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [6:0]  id_opcode;
   logic [2:0]  id_funct3;
   logic [4:0]  id_rd;
   logic        mem_valid, mem_wb_en, mem_is_load, mem_is_store, mem_illegal, redirect_valid;
   logic [31:0] mem_result, mem_store_data, redirect_pc;
   logic [4:0]  mem_rd;
   logic [2:0]  mem_funct3;

   int n_checks = 0;
   int n_pass   = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   ex_stage #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
      .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7b5(id_funct7b5), .id_rd(id_rd),
      .flush(flush), .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_result(mem_result),
      .mem_store_data(mem_store_data), .mem_rd(mem_rd), .mem_funct3(mem_funct3),
      .mem_wb_en(mem_wb_en), .mem_is_load(mem_is_load), .mem_is_store(mem_is_store),
      .mem_illegal(mem_illegal), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   // Instruction-level meaning of each encoding, straight from the ISA rules.
   function automatic exp_t ref_exec(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                                     input logic [4:0] rd, input logic [31:0] pc, rs1, rs2, imm);
      exp_t e;
      logic [31:0] b;
      logic alt;
      e = '0;
      e.res_known = 1'b1;
      e.store_data = rs2;
      e.rd = rd;
      e.f3 = f3;
      case (opc)
         OP, OPI: begin
            b = (opc == OP) ? rs2 : imm;
            alt = (opc == OP) ? f7 : (f7 && f3 == 3'd5);
            e.wb = 1'b1;
            if (opc == OP && f7 && f3 != 3'd0 && f3 != 3'd5) begin
               e.ill = 1'b1;
               e.res_known = 1'b0;
            end
            case (f3)
               3'd0: e.result = alt ? rs1 - b : rs1 + b;
               3'd1: e.result = rs1 << b[4:0];
               3'd2: e.result = ($signed(rs1) < $signed(b)) ? 32'd1 : 32'd0;
               3'd3: e.result = (rs1 < b) ? 32'd1 : 32'd0;
               3'd4: e.result = rs1 ^ b;
               3'd5: if (alt) e.result = $signed(rs1) >>> b[4:0];
                     else     e.result = rs1 >> b[4:0];
               3'd6: e.result = rs1 | b;
               default: e.result = rs1 & b;
            endcase
         end
         LUI:   begin e.result = imm;       e.wb = 1'b1; end
         AUIPC: begin e.result = pc + imm;  e.wb = 1'b1; end
         LD:    begin e.result = rs1 + imm; e.wb = 1'b1; e.ld = 1'b1; end
         ST:    begin e.result = rs1 + imm; e.st = 1'b1; end
         BR: begin
            e.target = pc + imm;
            case (f3)
               3'd0, 3'd1: begin
                  e.result = rs1 - rs2;
                  e.taken = (f3 == 3'd0) ? (rs1 == rs2) : (rs1 != rs2);
               end
               3'd4, 3'd5: begin
                  e.result = ($signed(rs1) < $signed(rs2)) ? 32'd1 : 32'd0;
                  e.taken = (f3 == 3'd4) ? ($signed(rs1) < $signed(rs2)) : !($signed(rs1) < $signed(rs2));
               end
               3'd6, 3'd7: begin
                  e.result = (rs1 < rs2) ? 32'd1 : 32'd0;
                  e.taken = (f3 == 3'd6) ? (rs1 < rs2) : !(rs1 < rs2);
               end
               default: begin e.ill = 1'b1; e.res_known = 1'b0; end
            endcase
         end
         JAL:  begin e.result = pc + 32'd4; e.wb = 1'b1; e.taken = 1'b1; e.target = pc + imm; end
         JALR: begin e.result = pc + 32'd4; e.wb = 1'b1; e.taken = 1'b1; e.target = (rs1 + imm) & 32'hFFFF_FFFE; end
         default: begin e.ill = 1'b1; e.res_known = 1'b0; end
      endcase
      if (e.ill) begin e.wb = 1'b0; e.ld = 1'b0; e.st = 1'b0; e.taken = 1'b0; end
      if (rd == 5'd0) e.wb = 1'b0;
      return e;
   endfunction

   task automatic drive_idle();
      id_valid = 1'b0;
      flush    = 1'b0;
   endtask

   task automatic drive_insn(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                             input logic [4:0] rd, input logic [31:0] pc, rs1, rs2, imm);
      id_valid = 1'b1; id_opcode = opc; id_funct3 = f3; id_funct7b5 = f7; id_rd = rd;
      id_pc = pc; id_rs1_data = rs1; id_rs2_data = rs2; id_imm = imm;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; mem_ready = 1'b1;
      drive_idle();
      drive_insn(OP, 3'd0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
      id_valid = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      n_checks++; if (mem_valid !== 1'b0) $display("FAIL rst_mem_valid: got %0b exp 0", mem_valid); else n_pass++;
      n_checks++; if (redirect_valid !== 1'b0) $display("FAIL rst_redirect: got %0b exp 0", redirect_valid); else n_pass++;
      n_checks++; if (mem_result !== 32'd0) $display("FAIL rst_result: got %h exp 0", mem_result); else n_pass++;
      n_checks++; if (id_ready !== 1'b1) $display("FAIL rst_id_ready: got %0b exp 1", id_ready); else n_pass++;
      rst_n = 1'b1;
      @(negedge clk); #1;
      n_checks++; if (id_ready !== 1'b1) $display("FAIL post_rst_id_ready: got %0b exp 1", id_ready); else n_pass++;
   endtask

   task automatic test_op_sub();
      @(negedge clk);
      drive_insn(OP, 3'd0, 1'b1, 5'd3, 32'h0, 32'd5, 32'd7, 32'd0);
      @(negedge clk); drive_idle(); #1;
      n_checks++; if (mem_valid !== 1'b1) $display("FAIL sub_valid: got %0b exp 1", mem_valid); else n_pass++;
      n_checks++; if (mem_result !== 32'hFFFF_FFFE) $display("FAIL sub_result: got %h exp fffffffe", mem_result); else n_pass++;
      n_checks++; if (mem_wb_en !== 1'b1) $display("FAIL sub_wb_en: got %0b exp 1", mem_wb_en); else n_pass++;
      n_checks++; if (mem_rd !== 5'd3) $display("FAIL sub_rd: got %0d exp 3", mem_rd); else n_pass++;
      @(negedge clk); #1;
      n_checks++; if (mem_valid !== 1'b0) $display("FAIL sub_drain: got %0b exp 0", mem_valid); else n_pass++;
   endtask

   task automatic test_branch_blt();
      @(negedge clk);
      drive_insn(BR, 3'd4, 1'b0, 5'd0, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8);
      @(negedge clk);
      drive_insn(OP, 3'd0, 1'b0, 5'd5, 32'h104, 32'd1, 32'd1, 32'd0);
      #1;
      n_checks++; if (redirect_valid !== 1'b1) $display("FAIL blt_redirect: got %0b exp 1", redirect_valid); else n_pass++;
      n_checks++; if (redirect_pc !== 32'hF8) $display("FAIL blt_target: got %h exp f8", redirect_pc); else n_pass++;
      n_checks++; if (id_ready !== 1'b1) $display("FAIL blt_id_ready: got %0b exp 1", id_ready); else n_pass++;
      n_checks++; if (mem_wb_en !== 1'b0) $display("FAIL blt_wb_en: got %0b exp 0", mem_wb_en); else n_pass++;
      @(negedge clk); drive_idle(); #1;
      n_checks++; if (redirect_valid !== 1'b0) $display("FAIL blt_pulse_len: got %0b exp 0", redirect_valid); else n_pass++;
      n_checks++; if (mem_valid !== 1'b0) $display("FAIL blt_wrong_path: got %0b exp 0", mem_valid); else n_pass++;
   endtask

   task automatic test_branch_bltu();
      @(negedge clk);
      drive_insn(BR, 3'd6, 1'b0, 5'd0, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8);
      @(negedge clk); drive_idle(); #1;
      n_checks++; if (redirect_valid !== 1'b0) $display("FAIL bltu_redirect: got %0b exp 0", redirect_valid); else n_pass++;
      n_checks++; if (mem_valid !== 1'b1) $display("FAIL bltu_valid: got %0b exp 1", mem_valid); else n_pass++;
      n_checks++; if (mem_wb_en !== 1'b0) $display("FAIL bltu_wb_en: got %0b exp 0", mem_wb_en); else n_pass++;
   endtask

   task automatic test_jalr();
      @(negedge clk);
      drive_insn(JALR, 3'd0, 1'b0, 5'd1, 32'h40, 32'h2003, 32'd0, 32'd4);
      @(negedge clk); drive_idle(); #1;
      n_checks++; if (redirect_valid !== 1'b1) $display("FAIL jalr_redirect: got %0b exp 1", redirect_valid); else n_pass++;
      n_checks++; if (redirect_pc !== 32'h2006) $display("FAIL jalr_target: got %h exp 2006", redirect_pc); else n_pass++;
      n_checks++; if (mem_result !== 32'h44) $display("FAIL jalr_link: got %h exp 44", mem_result); else n_pass++;
      n_checks++; if (mem_wb_en !== 1'b1) $display("FAIL jalr_wb_en: got %0b exp 1", mem_wb_en); else n_pass++;
   endtask

   task automatic test_stall_flush();
      @(negedge clk);
      mem_ready = 1'b1;
      drive_insn(OP, 3'd0, 1'b0, 5'd4, 32'h0, 32'd1, 32'd2, 32'd0);
      @(negedge clk);
      mem_ready = 1'b0;
      drive_insn(OPI, 3'd0, 1'b0, 5'd6, 32'h4, 32'd10, 32'd0, 32'd5);
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++; if (id_ready !== 1'b0) $display("FAIL stall_id_ready[%0d]: got %0b exp 0", i, id_ready); else n_pass++;
         n_checks++; if ({mem_valid, mem_result, mem_rd} !== {1'b1, 32'd3, 5'd4})
            $display("FAIL stall_hold[%0d]: got %0b/%h/%0d exp 1/3/4", i, mem_valid, mem_result, mem_rd); else n_pass++;
         @(negedge clk);
      end
      mem_ready = 1'b1;
      @(negedge clk);
      drive_insn(JAL, 3'd0, 1'b0, 5'd1, 32'h200, 32'd0, 32'd0, 32'h20);
      flush = 1'b1;
      #1;
      n_checks++; if ({mem_valid, mem_result, mem_rd} !== {1'b1, 32'd15, 5'd6})
         $display("FAIL stall_release: got %0b/%h/%0d exp 1/f/6", mem_valid, mem_result, mem_rd); else n_pass++;
      @(negedge clk); drive_idle(); #1;
      n_checks++; if (mem_valid !== 1'b0) $display("FAIL flush_valid: got %0b exp 0", mem_valid); else n_pass++;
      n_checks++; if (redirect_valid !== 1'b0) $display("FAIL flush_redirect: got %0b exp 0", redirect_valid); else n_pass++;
   endtask

   task automatic test_illegal();
      @(negedge clk);
      drive_insn(OP, 3'd1, 1'b1, 5'd7, 32'h0, 32'd3, 32'd1, 32'd0);
      @(negedge clk);
      drive_insn(BR, 3'd2, 1'b0, 5'd0, 32'h300, 32'd5, 32'd5, 32'h10);
      #1;
      n_checks++; if ({mem_valid, mem_illegal, mem_wb_en, redirect_valid} !== 4'b1100)
         $display("FAIL ill_op: got v/ill/wb/redir %b exp 1100", {mem_valid, mem_illegal, mem_wb_en, redirect_valid}); else n_pass++;
      @(negedge clk);
      drive_insn(BAD, 3'd0, 1'b0, 5'd9, 32'h304, 32'd1, 32'd1, 32'd0);
      #1;
      n_checks++; if ({mem_valid, mem_illegal, redirect_valid, mem_is_load, mem_is_store} !== 5'b11000)
         $display("FAIL ill_branch: got %b exp 11000", {mem_valid, mem_illegal, redirect_valid, mem_is_load, mem_is_store}); else n_pass++;
      @(negedge clk); drive_idle(); #1;
      n_checks++; if ({mem_valid, mem_illegal, mem_wb_en, redirect_valid} !== 4'b1100)
         $display("FAIL ill_opcode: got %b exp 1100", {mem_valid, mem_illegal, mem_wb_en, redirect_valid}); else n_pass++;
   endtask

   task automatic test_reset_mid_stall();
      @(negedge clk);
      mem_ready = 1'b1;
      drive_insn(JAL, 3'd0, 1'b0, 5'd1, 32'h80, 32'd0, 32'hDEAD, 32'h10);
      @(negedge clk); drive_idle(); mem_ready = 1'b0; #1;
      n_checks++; if ({redirect_valid, redirect_pc, mem_result} !== {1'b1, 32'h90, 32'h84})
         $display("FAIL jal_pre_reset: got %0b/%h/%h exp 1/90/84", redirect_valid, redirect_pc, mem_result); else n_pass++;
      @(negedge clk); #3;
      rst_n = 1'b0;
      #1;
      n_checks++; if ({mem_valid, redirect_valid, mem_wb_en, mem_rd, mem_result, mem_store_data, redirect_pc} !== '0)
         $display("FAIL async_reset: got v=%0b r=%0b wb=%0b rd=%0d res=%h sd=%h rpc=%h exp all 0",
                  mem_valid, redirect_valid, mem_wb_en, mem_rd, mem_result, mem_store_data, redirect_pc); else n_pass++;
      n_checks++; if (id_ready !== 1'b1) $display("FAIL reset_id_ready: got %0b exp 1", id_ready); else n_pass++;
      @(negedge clk); #2;
      rst_n = 1'b1;
      mem_ready = 1'b1;
   endtask

   task automatic test_random();
      logic        m_valid = 1'b0, m_redir = 1'b0, exp_ready, load;
      logic [31:0] m_redir_pc = '0, r;
      logic [75:0] act_v, exp_v;
      exp_t        e;
      exp_q.delete();
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         r = $urandom;
         case ($urandom_range(0, 9))
            0: id_opcode = OP;   1: id_opcode = OPI;  2: id_opcode = LUI;
            3: id_opcode = AUIPC; 4: id_opcode = LD;  5: id_opcode = ST;
            6: id_opcode = BR;   7: id_opcode = JAL;  8: id_opcode = JALR;
            default: id_opcode = BAD;
         endcase
         id_valid    = ($urandom_range(0, 3) != 0);
         id_funct3   = 3'($urandom_range(0, 7));
         id_funct7b5 = 1'($urandom_range(0, 1));
         id_rd       = 5'($urandom_range(0, 31));
         id_pc       = {$urandom, 2'b00} >> 2 << 2;
         id_rs1_data = $urandom;
         id_rs2_data = ($urandom_range(0, 3) == 0) ? id_rs1_data : $urandom;
         id_imm      = {{20{r[11]}}, r[11:0]};
         mem_ready   = ($urandom_range(0, 3) != 0);
         flush       = ($urandom_range(0, 15) == 0);
         #1;
         exp_ready = m_redir || !m_valid || mem_ready;
         n_checks++; if (id_ready !== exp_ready) $display("FAIL rnd_id_ready c%0d: got %0b exp %0b", c, id_ready, exp_ready); else n_pass++;
         n_checks++; if (mem_valid !== m_valid) $display("FAIL rnd_mem_valid c%0d: got %0b exp %0b", c, mem_valid, m_valid); else n_pass++;
         n_checks++; if (redirect_valid !== m_redir) $display("FAIL rnd_redirect c%0d: got %0b exp %0b", c, redirect_valid, m_redir); else n_pass++;
         if (m_redir) begin
            n_checks++; if (redirect_pc !== m_redir_pc) $display("FAIL rnd_redirect_pc c%0d: got %h exp %h", c, redirect_pc, m_redir_pc); else n_pass++;
         end
         if (m_valid && exp_q.size() > 0) begin
            e = exp_q[0];
            exp_v = {e.res_known ? e.result : 32'd0, e.store_data, e.rd, e.f3, e.wb, e.ld, e.st, e.ill};
            act_v = {e.res_known ? mem_result : 32'd0, mem_store_data, mem_rd, mem_funct3,
                     mem_wb_en, mem_is_load, mem_is_store, mem_illegal};
            n_checks++; if (act_v !== exp_v) $display("FAIL rnd_payload c%0d: got %h exp %h", c, act_v, exp_v); else n_pass++;
         end
         e = ref_exec(id_opcode, id_funct3, id_funct7b5, id_rd, id_pc, id_rs1_data, id_rs2_data, id_imm);
         load = id_valid && exp_ready && !flush && !m_redir;
         if (m_valid && (mem_ready || flush) && exp_q.size() > 0) void'(exp_q.pop_front());
         if (load) exp_q.push_back(e);
         m_valid = flush ? 1'b0 : (load ? 1'b1 : (m_valid && !mem_ready));
         m_redir = load && e.taken;
         if (load && e.taken) m_redir_pc = e.target;
      end
      @(negedge clk);
      drive_idle();
   endtask

   initial begin
      test_reset();
      test_op_sub();
      test_branch_blt();
      test_branch_bltu();
      test_jalr();
      test_stall_flush();
      test_illegal();
      test_reset_mid_stall();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
